// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array input feeder and output controller.
package sa_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic SEL_ACT = 1'b0;
  localparam logic SEL_WGT = 1'b1;

  localparam int SA_ROWS  = 8;
  localparam int SA_DEPTH = 8;
  localparam int SA_DW    = 8;

endpackage

// File: rtl/sa_skew_bank.sv
// One stream's tile buffer: sequential write fill plus diagonally skewed read lanes.
module sa_skew_bank
  import sa_pkg::*;
#(
  parameter int ROWS  = SA_ROWS,
  parameter int DEPTH = SA_DEPTH,
  parameter int DW    = SA_DW,
  parameter int CW    = $clog2(ROWS*DEPTH+1),
  parameter int TW    = $clog2(DEPTH+ROWS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               we,
  input  logic [DW-1:0]      wdata,
  input  logic [TW-1:0]      t,
  output logic               room,
  output logic               full,
  output logic [ROWS*DW-1:0] lanes
);

  localparam int N  = ROWS*DEPTH;
  localparam int AW = $clog2(N);

  // Element k lives at mem[k], i.e. vector k / ROWS on row k % ROWS.
  logic [DW-1:0] mem [N];
  logic [CW-1:0] cnt;

  assign room = (cnt < CW'(N));
  assign full = (cnt == CW'(N));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (we && room) begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (we && room) begin
      mem[cnt[AW-1:0]] <= wdata;
    end
  end

  always_comb begin
    lanes = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (int'(t) >= r && int'(t) - r < DEPTH) begin
        lanes[r*DW +: DW] = mem[AW'((int'(t) - r) * ROWS + r)];
      end
    end
  end

endmodule

// File: rtl/sa_input_feeder.sv
// Buffers one weight/activation tile from the host byte stream, then streams it
// into the PE array rows with a one-cycle-per-row diagonal skew.
//
// state | meaning
// LOAD  | accepting host writes; start honoured once both banks are full
// RUN   | step counter t sweeps 0..DEPTH+ROWS-2, one skewed wavefront step per cycle
module sa_input_feeder
  import sa_pkg::*;
#(
  parameter int ROWS  = SA_ROWS,
  parameter int DEPTH = SA_DEPTH,
  parameter int DW    = SA_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      in_data,
  input  logic               in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               fire,
  output logic [ROWS*DW-1:0] w_out,
  output logic [ROWS*DW-1:0] a_out
);

  localparam int TW   = $clog2(DEPTH+ROWS);
  localparam int LAST = DEPTH+ROWS-2;

  state_t            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic              run_end;
  logic              w_room, w_full, a_room, a_full;
  logic              w_we, a_we;
  logic [ROWS*DW-1:0] w_lanes, a_lanes;

  assign run_end = (state_q == RUN) && (t_q == TW'(LAST));
  assign w_we    = in_valid && in_ready && (in_sel == SEL_WGT);
  assign a_we    = in_valid && in_ready && (in_sel == SEL_ACT);

  sa_skew_bank #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) u_wgt (
    .clk(clk), .rst(rst), .clr(run_end), .we(w_we), .wdata(in_data),
    .t(t_q), .room(w_room), .full(w_full), .lanes(w_lanes)
  );

  sa_skew_bank #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) u_act (
    .clk(clk), .rst(rst), .clr(run_end), .we(a_we), .wdata(in_data),
    .t(t_q), .room(a_room), .full(a_full), .lanes(a_lanes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      LOAD: begin
        if (start && w_full && a_full) begin
          state_d = RUN;
          t_d     = '0;
        end
      end
      RUN: begin
        if (run_end) begin
          state_d = LOAD;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // busy covers the trailing fire cycle, which lands after the FSM is back in LOAD.
  always_comb begin
    in_ready = (state_q == LOAD) && ((in_sel == SEL_WGT) ? w_room : a_room);
    busy     = (state_q == RUN) || fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fire  <= 1'b0;
      done  <= 1'b0;
      w_out <= '0;
      a_out <= '0;
    end else begin
      fire  <= (state_q == RUN);
      done  <= fire && (state_q == LOAD);
      w_out <= (state_q == RUN) ? w_lanes : '0;
      a_out <= (state_q == RUN) ? a_lanes : '0;
    end
  end

endmodule

// File: tb/tb_sa_input_feeder.sv
// Directed bench for sa_input_feeder with a 4-row, 3-deep tile.
module tb_sa_input_feeder;

  localparam int ROWS  = 4;
  localparam int DEPTH = 3;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DW-1:0]     in_data = '0;
  logic              in_sel = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              start = 1'b0;
  logic              busy, done, fire;
  logic [ROWS*DW-1:0] w_out, a_out;

  int n_tests = 0;
  int n_fail  = 0;

  sa_input_feeder #(.ROWS(ROWS), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .start(start), .busy(busy), .done(done), .fire(fire),
    .w_out(w_out), .a_out(a_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Lane r at step s carries element k = (s-r)*ROWS + r when 0 <= s-r < DEPTH.
  function automatic logic [31:0] exp_bus(input logic [7:0] base, input int step);
    logic [31:0] e;
    e = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (step - r >= 0 && step - r < DEPTH) e[r*8 +: 8] = base + 8'((step - r) * ROWS + r);
    end
    return e;
  endfunction

  task automatic load_stream(input logic sel, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      in_sel = sel; in_valid = 1'b1; in_data = base + 8'(k);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL load_ready sel=%0d k=%0d got %b want 1", sel, k, in_ready);
      end
      tick;
    end
    if (n == ROWS*DEPTH) begin
      in_sel = sel; in_valid = 1'b1; in_data = 8'hEE;
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL load_full_ready sel=%0d got %b want 0", sel, in_ready);
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [7:0] wb, input logic [7:0] ab, input bit hold);
    int fires, dones, first_fire, done_at;
    fires = 0; dones = 0; first_fire = -1; done_at = -1;
    start = 1'b1;
    tick;
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || fire !== 1'b0) begin
      n_fail++; $display("FAIL %s_accept busy=%b fire=%b want busy=1 fire=0", name, busy, fire);
    end
    if (hold) begin in_valid = 1'b1; in_data = 8'hEE; end
    for (int c = 0; c < 12; c++) begin
      if (hold && c <= 5) begin
        in_sel = c[0];
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s_run_ready c=%0d got %b want 0", name, c, in_ready);
        end
        if (c == 5) in_valid = 1'b0;
      end
      if (fire === 1'b1) begin
        if (first_fire < 0) first_fire = c;
        n_tests++;
        if (w_out !== exp_bus(wb, fires) || a_out !== exp_bus(ab, fires) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_lanes step=%0d w=%h a=%h busy=%b want w=%h a=%h busy=1",
                   name, fires, w_out, a_out, busy, exp_bus(wb, fires), exp_bus(ab, fires));
        end
        fires++;
      end else begin
        n_tests++;
        if (w_out !== '0 || a_out !== '0) begin
          n_fail++; $display("FAIL %s_idle_zero c=%0d w=%h a=%h want 0", name, c, w_out, a_out);
        end
      end
      if (done === 1'b1) begin
        dones++; done_at = c;
        in_sel = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("FAIL %s_done_cycle in_ready=%b busy=%b want 1 0", name, in_ready, busy);
        end
      end
      tick;
    end
    n_tests++;
    if (first_fire != 1 || fires != ROWS+DEPTH-1) begin
      n_fail++; $display("FAIL %s_fire_window first=%0d count=%0d want first=1 count=6", name, first_fire, fires);
    end
    n_tests++;
    if (dones != 1 || done_at != 7) begin
      n_fail++; $display("FAIL %s_done_pulse count=%0d at=%0d want count=1 at=7", name, dones, done_at);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; start = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready sel=%0d got %b want 1", s, in_ready);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || fire !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl busy=%b done=%b fire=%b want 0 0 0", busy, done, fire);
    end
    n_tests++;
    if (w_out !== '0 || a_out !== '0) begin
      n_fail++; $display("FAIL reset_data w=%h a=%h want 0", w_out, a_out);
    end
  endtask

  task automatic test_load_run;
    load_stream(1'b1, 8'h10, 12);
    load_stream(1'b0, 8'h80, 12);
    run_check("basic", 8'h10, 8'h80, 1'b0);
  endtask

  task automatic test_lanes;
    logic [31:0] wtab [6];
    logic [31:0] atab [6];
    int idx;
    wtab = '{32'h0000_0010, 32'h0000_1114, 32'h0012_1518, 32'h1316_1900, 32'h171A_0000, 32'h1B00_0000};
    atab = '{32'h0000_0080, 32'h0000_8184, 32'h0082_8588, 32'h8386_8900, 32'h878A_0000, 32'h8B00_0000};
    idx = 0;
    load_stream(1'b1, 8'h10, 12);
    load_stream(1'b0, 8'h80, 12);
    start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (fire === 1'b1 && idx < 6) begin
        n_tests++;
        if (w_out !== wtab[idx] || a_out !== atab[idx]) begin
          n_fail++; $display("FAIL lanes_table cyc=%0d w=%h a=%h want w=%h a=%h", idx, w_out, a_out, wtab[idx], atab[idx]);
        end
        idx++;
      end
      tick;
    end
    n_tests++;
    if (idx != 6) begin
      n_fail++; $display("FAIL lanes_count got %0d want 6", idx);
    end
  endtask

  task automatic test_partial_start;
    load_stream(1'b0, 8'h80, 12);
    load_stream(1'b1, 8'h10, 11);
    start = 1'b1; tick; start = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL partial_busy got %b want 0", busy);
    end
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (fire !== 1'b0) begin
        n_fail++; $display("FAIL partial_fire c=%0d got %b want 0", c, fire);
      end
      tick;
    end
    load_stream(1'b1, 8'h1B, 1);
    in_sel = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL partial_full_ready got %b want 0", in_ready);
    end
    run_check("partial", 8'h10, 8'h80, 1'b0);
  endtask

  task automatic test_run_blocking;
    load_stream(1'b1, 8'h10, 12);
    load_stream(1'b0, 8'h80, 12);
    run_check("hold", 8'h10, 8'h80, 1'b1);
    load_stream(1'b1, 8'h20, 12);
    load_stream(1'b0, 8'h90, 12);
    run_check("second", 8'h20, 8'h90, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    load_stream(1'b1, 8'h10, 12);
    load_stream(1'b0, 8'h80, 12);
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    n_tests++;
    if (fire !== 1'b1 || w_out !== 32'h0012_1518) begin
      n_fail++; $display("FAIL midrst_third_fire fire=%b w=%h want 1 00121518", fire, w_out);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if (fire !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || w_out !== '0 || a_out !== '0) begin
      n_fail++; $display("FAIL midrst_outputs fire=%b busy=%b done=%b w=%h a=%h want all 0", fire, busy, done, w_out, a_out);
    end
    for (int s = 0; s < 2; s++) begin
      in_sel = s[0];
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++; $display("FAIL midrst_ready sel=%0d got %b want 1", s, in_ready);
      end
    end
    tick;
    load_stream(1'b1, 8'h30, 12);
    load_stream(1'b0, 8'hA0, 12);
    run_check("reload", 8'h30, 8'hA0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_load_run;
    test_lanes;
    test_partial_start;
    test_run_blocking;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
